// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the async FIFO write/read controllers.
//   ADDR_WIDTH  - default memory address width (depth = 2**ADDR_WIDTH)
//   SYNC_STAGES - default flop count of a pointer synchroniser
//   ptr_t       - pointer type, one bit wider than the address
//   bin2gray / gray2bin - code conversions on a zero-extended 32-bit
//   container. They are valid for any width up to 32 because the unused
//   upper bits stay zero. Callers cast the result back to their own width.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int ADDR_WIDTH  = 5;
  localparam int SYNC_STAGES = 2;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, built in log2(32) doubling steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: bundle between the producer/memory side and the FIFO
// write controller.
//   Wr_req      producer push request
//   Rd_ptr_gray Gray read pointer from the read clock domain (asynchronous)
//   Wr_en       write strobe to the memory
//   Wr_addr     write address to the memory
//   Wr_ptr_gray registered Gray write pointer for the read side
//   Full        registered full flag
//   Wr_level    fill level seen from the write domain
//   Overflow    sticky push-while-full flag
//   Almost_full only when WR_ALMOST_FULL_EN is defined
// Modports: master = environment side, slave = controller side.
`timescale 1ns/1ps
import fifo_pkg::*;

interface fifo_wr_ctrl_if #(
  parameter int Addr_width = ADDR_WIDTH
);
  logic                  Wr_req;
  logic [Addr_width:0]   Rd_ptr_gray;
  logic                  Wr_en;
  logic [Addr_width-1:0] Wr_addr;
  logic [Addr_width:0]   Wr_ptr_gray;
  logic                  Full;
  logic [Addr_width:0]   Wr_level;
  logic                  Overflow;
`ifdef WR_ALMOST_FULL_EN
  logic                  Almost_full;
`endif

  modport master (
    output Wr_req, Rd_ptr_gray,
    input  Wr_en, Wr_addr, Wr_ptr_gray, Full, Wr_level, Overflow
`ifdef WR_ALMOST_FULL_EN
    , input Almost_full
`endif
  );

  modport slave (
    input  Wr_req, Rd_ptr_gray,
    output Wr_en, Wr_addr, Wr_ptr_gray, Full, Wr_level, Overflow
`ifdef WR_ALMOST_FULL_EN
    , output Almost_full
`endif
  );
endinterface

// File: rtl/sync_ff.sv
// sync_ff: N-stage, W-bit synchroniser with asynchronous active-high reset.
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input (must change at most one bit at a time)
//   q   - synchronised output, N cycles behind d
`timescale 1ns/1ps
module sync_ff #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_reg [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < N; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[N-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the asynchronous FIFO.
// Keeps the write pointer in binary and Gray form, synchronises the read
// Gray pointer into clk, and derives Full, Wr_level and a sticky Overflow.
//   clk - write-domain clock
//   rst - asynchronous active-high reset
//   bus - fifo_wr_ctrl_if.slave (Wr_req/Rd_ptr_gray in; Wr_en, Wr_addr,
//         Wr_ptr_gray, Full, Wr_level, Overflow[, Almost_full] out)
// Optional feature macro: WR_ALMOST_FULL_EN adds the registered Almost_full
// output (threshold Almost_full_thresh).
`timescale 1ns/1ps
import fifo_pkg::*;

module fifo_wr_ctrl #(
  parameter int Addr_width         = ADDR_WIDTH,
  parameter int Sync_stages        = SYNC_STAGES,
  parameter int Almost_full_thresh = 28
) (
  input  logic clk,
  input  logic rst,
  fifo_wr_ctrl_if.slave bus
);

  localparam int PW = Addr_width + 1;

  logic [PW-1:0] wbin_reg, wbin_next;
  logic [PW-1:0] gray_reg, gray_next;
  logic [PW-1:0] rq_sync, rq_bin, full_cmp;
  logic          full_reg, ovf_reg;
  logic          wr_en;

  // Only the synchroniser touches the asynchronous read pointer.
  sync_ff #(.W(PW), .N(Sync_stages)) u_rq_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.Rd_ptr_gray),
    .q   (rq_sync)
  );

  always_comb begin
    // Masked by rst so nothing is written into the memory while the
    // pointers are held in reset.
    wr_en     = bus.Wr_req & ~full_reg & ~rst;
    wbin_next = wbin_reg + PW'(wr_en);
    gray_next = PW'(bin2gray(32'(wbin_next)));
    rq_bin    = PW'(gray2bin(32'(rq_sync)));
    // Write pointer exactly one lap ahead of the read pointer, expressed in
    // Gray code: the top two bits are inverted, the rest are equal.
    full_cmp  = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_reg <= '0;
      gray_reg <= '0;
      full_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      wbin_reg <= wbin_next;
      gray_reg <= gray_next;
      // Recomputed every cycle so a read can clear it even without pushes.
      full_reg <= (gray_next == full_cmp);
      if (bus.Wr_req && full_reg) begin
        ovf_reg <= 1'b1;
      end
    end
  end

`ifdef WR_ALMOST_FULL_EN
  logic af_reg;
  logic [PW-1:0] level_next;

  assign level_next = wbin_next - rq_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_reg <= 1'b0;
    end else begin
      af_reg <= (level_next >= PW'(Almost_full_thresh));
    end
  end

  assign bus.Almost_full = af_reg;
`endif

  assign bus.Wr_en       = wr_en;
  assign bus.Wr_addr     = wbin_reg[Addr_width-1:0];
  assign bus.Wr_ptr_gray = gray_reg;
  assign bus.Full        = full_reg;
  // Uses the lagging synchronised read pointer, so it never underestimates.
  assign bus.Wr_level    = wbin_reg - rq_bin;
  assign bus.Overflow    = ovf_reg;

endmodule
